// File: rtl/mux_arb_nin_pkg.sv
// Shared constants and helpers for the N-input round-robin mux (mux_arb_nin).
package mux_pkg;

  localparam int MUX_NUM_IN_DEF = 4;
  localparam int MUX_DATA_W_DEF = 32;

  // Index width that stays legal even for a degenerate single-input build.
  function automatic int sel_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_arb_nin_rr_arbiter.sv
// Combinational round-robin search: first requester at or after ptr, wrapping.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_IN = MUX_NUM_IN_DEF
) (
  input  logic [NUM_IN-1:0]        req,
  input  logic [sel_w(NUM_IN)-1:0] ptr,
  input  logic                     en,
  output logic [NUM_IN-1:0]        gnt,
  output logic [sel_w(NUM_IN)-1:0] gnt_idx
);

  localparam int SEL_W = sel_w(NUM_IN);

  always_comb begin
    int   k;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    for (int i = 0; i < NUM_IN; i++) begin
      k = int'(ptr) + i;
      if (k >= NUM_IN) k = k - NUM_IN;
      if (!found && req[k]) begin
        found   = 1'b1;
        gnt[k]  = en;
        gnt_idx = SEL_W'(k);
      end
    end
    // A disabled search reports channel 0 so the index never hints at a grant.
    if (!en) gnt_idx = '0;
  end

endmodule

// File: rtl/mux_arb_nin.sv
// NUM_IN-channel valid/ready mux with round-robin grant and a registered output.
// Optional burst locking is compiled in with `define MUX_ARB_LOCK_EN.
module mux_arb_nin
  import mux_pkg::*;
#(
  parameter int NUM_IN = MUX_NUM_IN_DEF,
  parameter int DATA_W = MUX_DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
`ifdef MUX_ARB_LOCK_EN
  input  logic [NUM_IN-1:0]        in_lock,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [sel_w(NUM_IN)-1:0] out_sel
);

  localparam int SEL_W = sel_w(NUM_IN);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [SEL_W-1:0]  r_sel;
  logic [SEL_W-1:0]  r_ptr;

  logic [NUM_IN-1:0] w_req;
  logic [NUM_IN-1:0] w_gnt;
  logic [SEL_W-1:0]  w_gnt_idx;
  logic [SEL_W-1:0]  w_ptr_inc;
  logic [DATA_W-1:0] w_gnt_data;
  logic              w_can_accept;
  logic              w_xfer;
  logic              w_lock_nxt;

  // The output register may refill in the same cycle it drains.
  assign w_can_accept = (!r_valid || out_ready) && !rst;

  rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
    .req     (w_req),
    .ptr     (r_ptr),
    .en      (w_can_accept),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign in_ready   = w_gnt;
  assign w_xfer     = |w_gnt;
  assign w_gnt_data = in_data[int'(w_gnt_idx)*DATA_W +: DATA_W];
  assign w_ptr_inc  = (w_gnt_idx == SEL_W'(NUM_IN-1)) ? '0 : w_gnt_idx + 1'b1;

`ifdef MUX_ARB_LOCK_EN
  logic             r_lock;
  logic [SEL_W-1:0] r_lock_ch;

  // While locked only the owning channel is searched, so idle owner means no grant.
  assign w_req      = r_lock ? (in_valid & (NUM_IN'(1) << r_lock_ch)) : in_valid;
  assign w_lock_nxt = in_lock[w_gnt_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock    <= 1'b0;
      r_lock_ch <= '0;
    end else if (w_xfer) begin
      r_lock    <= w_lock_nxt;
      r_lock_ch <= w_gnt_idx;
    end
  end
`else
  assign w_req      = in_valid;
  assign w_lock_nxt = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_gnt_data;
      r_sel   <= w_gnt_idx;
      if (!w_lock_nxt) r_ptr <= w_ptr_inc;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule

// File: tb/tb_mux_arb_nin.sv
// Self-checking bench for mux_arb_nin against a queue-free behavioural model.
module tb_mux_arb_nin;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    in_valid = '0;
  logic [N-1:0]    in_ready;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]    in_lock = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_sel;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          m_ptr;
  logic        m_ov;
  logic [DW-1:0] m_od;
  int          m_os;

  mux_arb_nin #(.NUM_IN(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef MUX_ARB_LOCK_EN
    .in_lock   (in_lock),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  function automatic int find_grant(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++)
      if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready(input logic [N-1:0] v, input logic ordy);
    logic [N-1:0] r;
    int g;
    r = '0;
    g = find_grant(v, m_ptr);
    if ((!m_ov || ordy) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_ov = 1'b0; m_od = '0; m_os = 0;
  endtask

  task automatic tick();
    int g;
    g = find_grant(in_valid, m_ptr);
    if (exp_ready(in_valid, out_ready) != '0) begin
      m_ov  = 1'b1;
      m_od  = in_data[g*DW +: DW];
      m_os  = g;
      m_ptr = (g + 1) % N;
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = '0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = '0; out_ready = 1'b1; in_data = '0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if ({out_valid, out_data, out_sel, in_ready} !== {1'b0, 32'h0, 2'd0, 4'b0}) begin
      n_fail++;
      $display("FAIL reset_state got v=%0b d=%h s=%0d r=%b want 0", out_valid, out_data, out_sel, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_tests++;
      if (in_ready !== 4'b0) begin
        n_fail++; $display("FAIL idle_ready cyc%0d got %b want 0000", c, in_ready);
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b0 || out_data !== 32'h0) begin
        n_fail++; $display("FAIL idle_out cyc%0d got v=%0b d=%h want v=0 d=0", c, out_valid, out_data);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single();
    in_valid = 4'b0100; in_data[2*DW +: DW] = 32'hAA; out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 4'b0100) begin
      n_fail++; $display("FAIL single_ready got %b want 0100", in_ready);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 32'hAA || out_sel !== 2'd2) begin
      n_fail++; $display("FAIL single_out got v=%0b d=%h s=%0d want v=1 d=aa s=2", out_valid, out_data, out_sel);
    end
    @(negedge clk);
    // ptr must now sit at 3, so channel 3 wins with all valid
    in_valid = 4'b1111;
    #1;
    n_tests++;
    if (in_ready !== 4'b1000) begin
      n_fail++; $display("FAIL single_ptr got %b want 1000", in_ready);
    end
    tick();
    @(negedge clk);
    in_valid = '0;
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 32'h10 + i;
    in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_tests++;
      if (in_ready !== 4'(1 << (i % N))) begin
        n_fail++; $display("FAIL fair_ready beat%0d got %b want %b", i, in_ready, 4'(1 << (i % N)));
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_sel !== 2'(i % N) || out_data !== 32'h10 + (i % N)) begin
        n_fail++;
        $display("FAIL fair_out beat%0d got v=%0b s=%0d d=%h want v=1 s=%0d d=%h",
                 i, out_valid, out_sel, out_data, i % N, 32'h10 + (i % N));
      end
      @(negedge clk);
    end
    in_valid = '0;
  endtask

  task automatic test_stall();
    do_reset();
    in_valid = 4'b0011; in_data[0 +: DW] = 32'hA0; in_data[DW +: DW] = 32'hA1; out_ready = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 4'b0001) begin
      n_fail++; $display("FAIL stall_first_ready got %b want 0001", in_ready);
    end
    tick();
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if (in_ready !== 4'b0) begin
        n_fail++; $display("FAIL stall_ready cyc%0d got %b want 0000", c, in_ready);
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 32'hA0) begin
        n_fail++; $display("FAIL stall_hold cyc%0d got v=%0b s=%0d d=%h want v=1 s=0 d=a0", c, out_valid, out_sel, out_data);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 4'b0010) begin
      n_fail++; $display("FAIL stall_release_ready got %b want 0010", in_ready);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 32'hA1) begin
      n_fail++; $display("FAIL stall_release_out got v=%0b s=%0d d=%h want v=1 s=1 d=a1", out_valid, out_sel, out_data);
    end
    @(negedge clk);
    in_valid = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 4'b0010; in_data[DW +: DW] = 32'h11; out_ready = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if ({out_valid, out_data, out_sel, in_ready} !== {1'b0, 32'h0, 2'd0, 4'b0}) begin
      n_fail++;
      $display("FAIL async_reset got v=%0b d=%h s=%0d r=%b want all 0", out_valid, out_data, out_sel, in_ready);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 4'b1010; out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 4'b0010) begin
      n_fail++; $display("FAIL post_reset_grant got %b want 0010", in_ready);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_sel !== 2'd1) begin
      n_fail++; $display("FAIL post_reset_out got v=%0b s=%0d want v=1 s=1", out_valid, out_sel);
    end
    @(negedge clk);
    in_valid = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid  = 4'($urandom);
      out_ready = ($urandom % 4) != 0;
      for (int i = 0; i < N; i++) in_data[i*DW +: DW] = $urandom;
      #1;
      n_tests++;
      if (in_ready !== exp_ready(in_valid, out_ready)) begin
        n_fail++; $display("FAIL rand_ready cyc%0d got %b want %b", c, in_ready, exp_ready(in_valid, out_ready));
      end
      tick();
      n_tests++;
      if (out_valid !== m_ov || out_data !== m_od || out_sel !== 2'(m_os)) begin
        n_fail++;
        $display("FAIL rand_out cyc%0d got v=%0b d=%h s=%0d want v=%0b d=%h s=%0d",
                 c, out_valid, out_data, out_sel, m_ov, m_od, m_os);
      end
      @(negedge clk);
    end
    in_valid = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_fairness();
    test_stall();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
